// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-rate divider, horizontal/vertical counters and
// registered sync/active-video flags aligned with the coordinates they describe.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       pixel_tick,
  output logic       line_end,
  output logic       frame_end
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_too_large
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("vga_sync_gen: CLK_DIV must be at least 1");
    end
  endgenerate

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_DISP   = 11'(H_DISPLAY);
  localparam logic [10:0] V_DISP   = 11'(V_DISPLAY);
  localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_STOP  = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_STOP  = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hpos_q, hpos_d;
  logic [9:0]       vpos_q, vpos_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             display_q, display_d;

  assign pixel_tick = (div_q == DIV_LAST);
  assign line_end   = pixel_tick && (hpos_q == H_LAST);
  assign frame_end  = line_end && (vpos_q == V_LAST);

  // Flags are decoded from the next coordinates so that, once registered,
  // they line up with the coordinates shown in the same cycle.
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (pixel_tick) begin
      div_d = '0;
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
      end else begin
        hpos_d = hpos_q + 10'd1;
      end
    end

    hsync_d = (({1'b0, hpos_d} >= HS_START) && ({1'b0, hpos_d} < HS_STOP)) ? HS_POL : ~HS_POL;
    vsync_d = (({1'b0, vpos_d} >= VS_START) && ({1'b0, vpos_d} < VS_STOP)) ? VS_POL : ~VS_POL;
    display_d = ({1'b0, hpos_d} < H_DISP) && ({1'b0, vpos_d} < V_DISP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      hpos_q    <= '0;
      vpos_q    <= '0;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      display_q <= 1'b1;
    end else begin
      div_q     <= div_d;
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      display_q <= display_d;
    end
  end

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = display_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three configurations driven together with random resets,
// every cycle compared against an arithmetic raster model plus period/width measurements.
module tb_vga_sync_gen;

  logic       clk;
  logic       reset;
  logic [2:0] hsyncW, vsyncW, deW, tickW, leW, feW;
  logic [9:0] hposW [3];
  logic [9:0] vposW [3];

  int checkCount;
  int errorCount;
  int n;
  bit modelValid;

  int defLineCyc, defHsLow, defDe;
  int altLineCyc, altHsHigh;
  int smlFrameCyc, smlVsLow;
  bit smlAfterFe, smlPrevVs, smlPrevValid;

  // 0: default timing, 1: CLK_DIV=1 with positive syncs, 2: tiny raster for frame-level checks
  vga_sync_gen dutDef (
    .clk(clk), .reset(reset), .hsync(hsyncW[0]), .vsync(vsyncW[0]), .display_on(deW[0]),
    .hpos(hposW[0]), .vpos(vposW[0]), .pixel_tick(tickW[0]), .line_end(leW[0]), .frame_end(feW[0])
  );

  vga_sync_gen #(.CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1)) dutAlt (
    .clk(clk), .reset(reset), .hsync(hsyncW[1]), .vsync(vsyncW[1]), .display_on(deW[1]),
    .hpos(hposW[1]), .vpos(vposW[1]), .pixel_tick(tickW[1]), .line_end(leW[1]), .frame_end(feW[1])
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dutSml (
    .clk(clk), .reset(reset), .hsync(hsyncW[2]), .vsync(vsyncW[2]), .display_on(deW[2]),
    .hpos(hposW[2]), .vpos(vposW[2]), .pixel_tick(tickW[2]), .line_end(leW[2]), .frame_end(feW[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Raster position follows from the number of clocks since reset: n/cd pixels elapsed.
  function automatic logic [25:0] model(input int cnt, input int cd,
                                        input int hd, input int hf, input int hs, input int hb,
                                        input int vd, input int vf, input int vs, input int vb,
                                        input bit hp, input bit vp);
    int ht, vt, pix, h, v;
    bit tick, le, fe, hsy, vsy, de;
    ht   = hd + hf + hs + hb;
    vt   = vd + vf + vs + vb;
    pix  = cnt / cd;
    h    = pix % ht;
    v    = (pix / ht) % vt;
    tick = ((cnt % cd) == cd - 1);
    le   = tick && (h == ht - 1);
    fe   = le && (v == vt - 1);
    hsy  = (h >= hd + hf && h < hd + hf + hs) ? hp : !hp;
    vsy  = (v >= vd + vf && v < vd + vf + vs) ? vp : !vp;
    de   = (h < hd) && (v < vd);
    return {hsy, vsy, de, 10'(h), 10'(v), tick, le, fe};
  endfunction

  function automatic logic [25:0] expOf(input int k);
    case (k)
      0:       return model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
      1:       return model(n, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1);
      default: return model(n, 3, 8, 2, 3, 2, 6, 1, 2, 2, 1'b0, 1'b0);
    endcase
  endfunction

  function automatic logic [25:0] obsOf(input int k);
    return {hsyncW[k], vsyncW[k], deW[k], hposW[k], vposW[k], tickW[k], leW[k], feW[k]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearStats();
    defLineCyc  = 0; defHsLow  = 0; defDe = 0;
    altLineCyc  = 0; altHsHigh = 0;
    smlFrameCyc = 0; smlVsLow  = 0;
    smlAfterFe  = 1'b0;
  endtask

  task automatic compareAll();
    checkOutput("modelDef", 32'(obsOf(0)), 32'(expOf(0)));
    checkOutput("modelAlt", 32'(obsOf(1)), 32'(expOf(1)));
    checkOutput("modelSml", 32'(obsOf(2)), 32'(expOf(2)));

    defLineCyc++;
    defHsLow += int'(!hsyncW[0]);
    defDe    += int'(deW[0]);
    if (leW[0]) begin
      checkOutput("defLinePeriod", 32'(defLineCyc), 32'd1600);
      checkOutput("defHsyncLow", 32'(defHsLow), 32'd192);
      checkOutput("defDisplayOn", 32'(defDe), (vposW[0] < 10'd480) ? 32'd1280 : 32'd0);
      defLineCyc = 0; defHsLow = 0; defDe = 0;
    end

    altLineCyc++;
    altHsHigh += int'(hsyncW[1]);
    if (leW[1]) begin
      checkOutput("altLinePeriod", 32'(altLineCyc), 32'd800);
      checkOutput("altHsyncHigh", 32'(altHsHigh), 32'd96);
      altLineCyc = 0; altHsHigh = 0;
    end

    if (smlAfterFe) begin
      checkOutput("smlAfterWrap", 32'({hposW[2], vposW[2], deW[2]}), 32'({10'd0, 10'd0, 1'b1}));
      smlAfterFe = 1'b0;
    end
    if (smlPrevValid && (vsyncW[2] != smlPrevVs))
      checkOutput("smlVsEdgeHpos", 32'(hposW[2]), 32'd0);
    smlPrevVs    = vsyncW[2];
    smlPrevValid = 1'b1;
    smlFrameCyc++;
    smlVsLow += int'(!vsyncW[2]);
    if (feW[2]) begin
      checkOutput("smlFramePeriod", 32'(smlFrameCyc), 32'd495);
      checkOutput("smlVsyncLow", 32'(smlVsLow), 32'd90);
      checkOutput("smlWrapCycle", 32'({leW[2], hposW[2], vposW[2]}), 32'({1'b1, 10'd14, 10'd10}));
      smlFrameCyc = 0; smlVsLow = 0;
      smlAfterFe  = 1'b1;
    end
  endtask

  // One clock: drive reset for the coming edge, then sample at the falling edge.
  task automatic applyStimulus(input bit r);
    reset = r;
    @(posedge clk);
    if (r) begin
      n = 0;
      modelValid = 1'b1;
      clearStats();
    end else begin
      n = n + 1;
    end
    @(negedge clk);
    if (modelValid) compareAll();
  endtask

  initial begin
    int cnt;
    int hold;
    checkCount   = 0;
    errorCount   = 0;
    n            = 0;
    modelValid   = 1'b0;
    smlPrevValid = 1'b0;
    smlPrevVs    = 1'b0;
    clearStats();
    reset = 1'b1;
    @(negedge clk);

    repeat (3) applyStimulus(1'b1);
    checkOutput("resetValues",
                32'({hsyncW[0], vsyncW[0], deW[0], hposW[0], vposW[0], feW[0]}),
                32'({3'b111, 10'd0, 10'd0, 1'b0}));

    cnt = 0;
    while (hposW[0] == 10'd0 && cnt < 10) begin
      cnt++;
      applyStimulus(1'b0);
    end
    checkOutput("firstHposStep", 32'(cnt), 32'd2);

    repeat (3300) applyStimulus(1'b0);

    cnt = 0;
    while (!(hposW[2] == 10'd11 && vposW[2] == 10'd7) && cnt < 2000) begin
      cnt++;
      applyStimulus(1'b0);
    end
    checkOutput("midFrameReached", 32'(cnt < 2000), 32'd1);
    checkOutput("midFrameSyncs", 32'({hsyncW[2], vsyncW[2]}), 32'b00);
    applyStimulus(1'b1);
    checkOutput("midFrameReset", 32'({hposW[2], vposW[2], hsyncW[2], vsyncW[2]}),
                32'({10'd0, 10'd0, 1'b1, 1'b1}));
    cnt = 0;
    while (hposW[2] == 10'd0 && cnt < 10) begin
      cnt++;
      applyStimulus(1'b0);
    end
    checkOutput("firstPixelWidth", 32'(cnt), 32'd3);

    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 2499) == 0) begin
        hold = $urandom_range(1, 3);
        repeat (hold) applyStimulus(1'b1);
      end else begin
        applyStimulus(1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
